signed_window_stats: RTL
========================

SIGNED_WINDOW_STATS -- requirements
Module: signed_window_stats

Interface
REQ-001 The block SHALL have parameter WIN, default 8, meaning samples per statistics window, legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port q_in, input, signed 8, the sample from the upstream up/down counter output q.
REQ-005 The block SHALL have port q_valid, input, 1, meaning q_in is offered this cycle.
REQ-006 The block SHALL have port ovf_in, input, 1, the upstream overflow/underflow flag qualified by q_valid.
REQ-007 The block SHALL have port in_ready, output, 1, meaning a sample is accepted this cycle when q_valid is also 1.
REQ-008 The block SHALL have port stat_valid, output, 1, meaning window results are presented.
REQ-009 The block SHALL have port stat_ready, input, 1, the consumer acknowledge.
REQ-010 The block SHALL have port sum, output, signed 12, the two's-complement sum of the window samples.
REQ-011 The block SHALL have ports min and max, output, signed 8 each, the window minimum and maximum.
REQ-012 The block SHALL have port evt_count, output, unsigned 4, the count of overflow/wrap events in the window.

Function
REQ-013 The block SHALL implement two states: ACCUM, with in_ready=1 and stat_valid=0, and HOLD, with in_ready=0 and stat_valid=1.
REQ-014 In ACCUM, the block SHALL accept a sample only when q_valid=1; cycles with q_valid=0 SHALL leave all state unchanged.
REQ-015 Each accepted sample SHALL be sign-extended to 12 bits and added to the running sum; no saturation is applied, since 16*(-128)=-2048 and 16*127=2032 both fit.
REQ-016 The first accepted sample of a window SHALL load the running min and max directly; later samples SHALL update them with signed compares.
REQ-017 An accepted sample SHALL count as an event when ovf_in=1, or when it wraps relative to the previous accepted sample (prev=+127 and cur=-128, or prev=-128 and cur=+127).
REQ-018 A sample matching both conditions in REQ-017 SHALL count once.
REQ-019 The event count SHALL saturate at 15.
REQ-020 The previous-sample register SHALL persist across window boundaries.
REQ-021 A prev_valid flag, cleared by reset and set on the first accepted sample, SHALL gate wrap detection.
REQ-022 An internal sample counter SHALL advance on each accepted sample.
REQ-023 On acceptance of the WIN-th sample, the block SHALL register sum/min/max/evt_count into the output registers and enter HOLD, with stat_valid=1 on the next cycle (latency 1 cycle).
REQ-024 In HOLD, the outputs SHALL remain stable and samples SHALL NOT be accepted.
REQ-025 When stat_valid=1 and stat_ready=1, the block SHALL return to ACCUM on the next cycle and clear the running accumulators.
REQ-026 The block SHALL NOT accept a sample in the same cycle as the HOLD-to-ACCUM handshake.
REQ-027 The output registers (sum, min, max, evt_count) SHALL change only on window completion and SHALL otherwise hold their last values.

Reset
REQ-028 With rst=1 at a rising edge, the next state SHALL be ACCUM with the sample counter, running sum, evt_count and prev_valid all set to 0.
REQ-029 After reset, outputs SHALL read stat_valid=0, in_ready=1, sum=0, min=0, max=0, evt_count=0.
REQ-030 rst SHALL take priority over every other input, including mid-window and during HOLD.
REQ-031 A partially accumulated window SHALL be discarded on reset.

Verification (WIN=4 unless stated)
REQ-032 Basic window: samples 10, -20, 30, -5 on consecutive cycles -> one cycle after the 4th sample, stat_valid=1, sum=15, min=-20, max=30, evt_count=0.
REQ-033 Negative extreme: four samples of -128 -> sum=-512 (12'hE00), min=max=-128.
REQ-034 Wrap detection: samples 126, 127, -128, -127 with ovf_in=0 -> evt_count=1, min=-128, max=127, sum=-2; the same sequence with ovf_in=1 on -128 -> evt_count=1.
REQ-035 Back-pressure: complete a window, then hold stat_ready=0 for 5 cycles with q_valid=1 -> in_ready=0 and outputs unchanged for all 5 cycles; on stat_ready=1 the next window starts fresh and its sum counts only new samples.
REQ-036 Reset mid-window: accept 2 samples (50, 50), pulse rst, then feed 1, 2, 3, 4 -> sum=10, min=1, max=4, evt_count=0, and no wrap is flagged on the first post-reset sample.
REQ-037 Saturation (WIN=16): 16 samples all with ovf_in=1 -> evt_count=15; 16 samples of +127 -> sum=2032.

Source files
------------

// File: rtl/signed_window_stats.sv
// Windowed sum/min/max/event statistics over WIN signed counter samples; results appear 1 cycle after the WIN-th accept.
// Input stalls (in_ready=0) while a finished window is held until stat_ready; no sample is taken on the release cycle.
module signed_window_stats #(
    parameter int WIN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [7:0]  q_in,
    input  logic               q_valid,
    input  logic               ovf_in,
    output logic               in_ready,
    output logic               stat_valid,
    input  logic               stat_ready,
    output logic signed [11:0] sum,
    output logic signed [7:0]  min,
    output logic signed [7:0]  max,
    output logic [3:0]         evt_count
);

    localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIN - 1);

    typedef enum logic {
        ST_ACCUM,
        ST_HOLD
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CW-1:0]       r_cnt;
    logic signed [11:0]  r_acc_sum;
    logic signed [7:0]   r_acc_min;
    logic signed [7:0]   r_acc_max;
    logic [3:0]          r_acc_evt;
    logic signed [7:0]   r_prev;
    logic                r_prev_valid;

    logic signed [11:0]  r_out_sum;
    logic signed [7:0]   r_out_min;
    logic signed [7:0]   r_out_max;
    logic [3:0]          r_out_evt;

    logic                w_accept;
    logic                w_last;
    logic                w_release;
    logic                w_first;
    logic                w_wrap;
    logic                w_evt_hit;
    logic signed [11:0]  w_q_ext;
    logic signed [11:0]  w_sum_nxt;
    logic signed [7:0]   w_min_nxt;
    logic signed [7:0]   w_max_nxt;
    logic [3:0]          w_evt_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        stat_valid  = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                stat_valid = 1'b1;
                if (stat_ready) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase
    end

    assign w_accept  = (r_state == ST_ACCUM) && q_valid;
    assign w_last    = w_accept && (r_cnt == LAST);
    assign w_release = (r_state == ST_HOLD) && stat_ready;
    assign w_first   = (r_cnt == '0);

    // Full 12-bit sum cannot overflow: 16 samples span -2048..2032.
    assign w_q_ext   = {{4{q_in[7]}}, q_in};
    assign w_sum_nxt = r_acc_sum + w_q_ext;
    assign w_min_nxt = (w_first || (q_in < r_acc_min)) ? q_in : r_acc_min;
    assign w_max_nxt = (w_first || (q_in > r_acc_max)) ? q_in : r_acc_max;

    // A wrap is a full-scale jump between consecutive accepted samples.
    assign w_wrap    = r_prev_valid &&
                       (((r_prev == 8'sh7F) && (q_in == 8'sh80)) ||
                        ((r_prev == 8'sh80) && (q_in == 8'sh7F)));
    assign w_evt_hit = ovf_in || w_wrap;
    assign w_evt_nxt = (w_evt_hit && (r_acc_evt != 4'hF)) ? (r_acc_evt + 4'd1) : r_acc_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_acc_sum    <= '0;
            r_acc_min    <= '0;
            r_acc_max    <= '0;
            r_acc_evt    <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_out_sum    <= '0;
            r_out_min    <= '0;
            r_out_max    <= '0;
            r_out_evt    <= '0;
        end else if (w_accept) begin
            r_acc_sum    <= w_sum_nxt;
            r_acc_min    <= w_min_nxt;
            r_acc_max    <= w_max_nxt;
            r_acc_evt    <= w_evt_nxt;
            r_prev       <= q_in;
            r_prev_valid <= 1'b1;
            r_cnt        <= w_last ? '0 : (r_cnt + 1'b1);
            if (w_last) begin
                r_out_sum <= w_sum_nxt;
                r_out_min <= w_min_nxt;
                r_out_max <= w_max_nxt;
                r_out_evt <= w_evt_nxt;
            end
        end else if (w_release) begin
            r_acc_sum <= '0;
            r_acc_evt <= '0;
        end
    end

    assign sum       = r_out_sum;
    assign min       = r_out_min;
    assign max       = r_out_max;
    assign evt_count = r_out_evt;

    // A presented window must not move while the consumer stalls.
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (stat_valid && !stat_ready) |=> ($stable(sum) && $stable(min) && $stable(max) && $stable(evt_count)));

    a_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(in_ready && stat_valid));

endmodule
